axi_addr_arbiter: RTL and testbench
===================================

// Module: axi_addr_arbiter
// PURPOSE
//  Address-channel arbiter + register slice between three AXI masters and the address decoder.
//  One instance per channel (AR, AW). Selects one requesting master and registers its address beat.
//  Tags the ID with the master index and presents a single ADDR/VALID stream to the decoder.
//  Returns the decoder's READY to the granted master only.
// PARAMETERS
//  IDW   4   master-side ID width
//  AW    32  address width
//  IDSW  8   slave-side ID width, = IDW+4, upper 4 bits carry master index
// PORTS
//  ACLK           in   1        clock, all logic on rising edge
//  ARESET         in   1        synchronous, active-high reset
//  ID_Mi          in   IDW      master i ID (i = 0 CPU-IF, 1 CPU-MEM, 2 DMA)
//  ADDR_Mi        in   AW       master i address
//  LEN_Mi         in   4        master i burst length-1
//  SIZE_Mi        in   3        master i beat size
//  BURST_Mi       in   2        master i burst type
//  VALID_Mi       in   1        master i request
//  READY_Mi       out  1        master i beat accepted
//  IDS_S          out  IDSW     {4'(master idx), ID} to decoder/slaves
//  ADDR_S         out  AW       registered address to decoder
//  LEN_S          out  4        registered length
//  SIZE_S         out  3        registered size
//  BURST_S        out  2        registered burst type
//  VALID_S        out  1        registered valid to decoder
//  READY_S        in   1        READY returned by decoder
// BEHAVIOUR
//  - Reset (ARESET=1 at edge): VALID_S=0, IDS_S/ADDR_S/LEN_S/SIZE_S/BURST_S=0, RR pointer -> M0 highest.
//    READY_Mi=0 while ARESET=1. Reset mid-transfer discards the held beat; no handshake to decoder.
//  - Output register states: EMPTY (VALID_S=0), FULL (VALID_S=1).
//  - load = ~VALID_S | READY_S (register empty or draining this cycle).
//  - grant: one-hot, combinational from current VALID_Mi, computed only when load=1.
//  - READY_Mi = load & grant[i] & ~ARESET. Handshake with master i = VALID_Mi & READY_Mi.
//  - On master handshake: register captures master fields, IDS_S = {4'(i), ID_Mi}, VALID_S=1 next cycle.
//  - FULL & READY_S & no new grant -> EMPTY. FULL & READY_S & grant -> stays FULL with new beat (back-to-back, 1 beat/cycle).
//  - FULL & ~READY_S: outputs held stable, all READY_Mi=0 (AXI stability rule on VALID_S side).
//  - Latency: master handshake at cycle N -> VALID_S at cycle N+1. Throughput 1 beat/cycle.
//  - No request (all VALID_Mi=0) with load=1: no grant, register goes/stays EMPTY, pointer unchanged.
//  - Master dropping VALID before handshake: no effect; grant re-evaluated every load cycle.
//  - Pointer updates only on a completed master handshake.
//  - IDS upper nibble values: M0=4'h0, M1=4'h1, M2=4'h2; upper-nibble values 3..F never produced.
// CONFIGURATION
//  AXI_ARB_RR_EN defined: round-robin; after granting Mk, priority order is M(k+1), M(k+2), Mk (mod 3).
//  AXI_ARB_RR_EN undefined: fixed priority M0 > M1 > M2, pointer logic removed; M2 may starve.
// TESTING
//  1 reset: ARESET=1 two cycles, all VALID_Mi=1 -> VALID_S=0, all READY_Mi=0, outputs 0.
//  2 single: VALID_M1=1, ID_M1=4'h3, ADDR_M1=32'h0002_0010, READY_S=1 -> READY_M1=1 cycle N;
//    cycle N+1 VALID_S=1, IDS_S=8'h13, ADDR_S=32'h0002_0010.
//  3 stall: FULL with READY_S=0 for 5 cycles, VALID_M0=1 -> outputs unchanged, READY_M0=0;
//    READY_S=1 -> READY_M0=1 same cycle, M0 beat on VALID_S next cycle.
//  4 contention, AXI_ARB_RR_EN defined: all three VALID held, READY_S=1 -> grants M0,M1,M2,M0
//    on consecutive cycles; IDS_S nibble 0,1,2,0.
//  5 contention, AXI_ARB_RR_EN undefined: M0 and M2 held valid -> M0 granted every cycle, READY_M2=0.
//  6 reset mid-op: VALID_S=1, READY_S=0, assert ARESET one cycle -> VALID_S=0 next cycle, no READY_Mi pulse.

Source files
------------

// File: rtl/axi_addr_arbiter.sv
// Address-channel arbiter and register slice for three AXI masters (AR or AW).
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise fixed priority M0 > M1 > M2.
//
// state | meaning
// EMPTY | no beat held, VALID_S=0
// FULL  | beat held for decoder, VALID_S=1
module axi_addr_arbiter #(
  parameter int IDW  = 4,
  parameter int AW   = 32,
  parameter int IDSW = 8
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [IDW-1:0]  ID_M0,
  input  logic [AW-1:0]   ADDR_M0,
  input  logic [3:0]      LEN_M0,
  input  logic [2:0]      SIZE_M0,
  input  logic [1:0]      BURST_M0,
  input  logic            VALID_M0,
  output logic            READY_M0,
  input  logic [IDW-1:0]  ID_M1,
  input  logic [AW-1:0]   ADDR_M1,
  input  logic [3:0]      LEN_M1,
  input  logic [2:0]      SIZE_M1,
  input  logic [1:0]      BURST_M1,
  input  logic            VALID_M1,
  output logic            READY_M1,
  input  logic [IDW-1:0]  ID_M2,
  input  logic [AW-1:0]   ADDR_M2,
  input  logic [3:0]      LEN_M2,
  input  logic [2:0]      SIZE_M2,
  input  logic [1:0]      BURST_M2,
  input  logic            VALID_M2,
  output logic            READY_M2,
  output logic [IDSW-1:0] IDS_S,
  output logic [AW-1:0]   ADDR_S,
  output logic [3:0]      LEN_S,
  output logic [2:0]      SIZE_S,
  output logic [1:0]      BURST_S,
  output logic            VALID_S,
  input  logic            READY_S
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           load;
  logic           hs;
  logic [3:0]     req;
  logic [3:0]     grant;
  logic [1:0]     gnt_idx;
  logic [IDW-1:0] sel_id;
  logic [AW-1:0]  sel_addr;
  logic [3:0]     sel_len;
  logic [2:0]     sel_size;
  logic [1:0]     sel_burst;

  assign req  = {1'b0, VALID_M2, VALID_M1, VALID_M0};
  assign load = (state_q == EMPTY) | READY_S;
  assign hs   = (|grant) & ~ARESET;

`ifdef AXI_ARB_RR_EN
  // ptr_q is the master with highest priority this cycle
  logic [1:0] ptr_q;
  logic [1:0] cand1, cand2;

  assign cand1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
  assign cand2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;

  always_comb begin
    grant   = '0;
    gnt_idx = 2'd0;
    if (load) begin
      if (req[ptr_q]) begin
        gnt_idx = ptr_q;
        grant[ptr_q] = 1'b1;
      end else if (req[cand1]) begin
        gnt_idx = cand1;
        grant[cand1] = 1'b1;
      end else if (req[cand2]) begin
        gnt_idx = cand2;
        grant[cand2] = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) ptr_q <= 2'd0;
    else if (hs) ptr_q <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end
`else
  always_comb begin
    grant   = '0;
    gnt_idx = 2'd0;
    if (load) begin
      if (req[0]) begin
        gnt_idx = 2'd0;
        grant[0] = 1'b1;
      end else if (req[1]) begin
        gnt_idx = 2'd1;
        grant[1] = 1'b1;
      end else if (req[2]) begin
        gnt_idx = 2'd2;
        grant[2] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_id    = ID_M0;
    sel_addr  = ADDR_M0;
    sel_len   = LEN_M0;
    sel_size  = SIZE_M0;
    sel_burst = BURST_M0;
    case (gnt_idx)
      2'd1: begin
        sel_id    = ID_M1;
        sel_addr  = ADDR_M1;
        sel_len   = LEN_M1;
        sel_size  = SIZE_M1;
        sel_burst = BURST_M1;
      end
      2'd2: begin
        sel_id    = ID_M2;
        sel_addr  = ADDR_M2;
        sel_len   = LEN_M2;
        sel_size  = SIZE_M2;
        sel_burst = BURST_M2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hs)        state_d = FULL;
    else if (load) state_d = EMPTY;
  end

  always_comb begin
    VALID_S  = (state_q == FULL);
    READY_M0 = grant[0] & ~ARESET;
    READY_M1 = grant[1] & ~ARESET;
    READY_M2 = grant[2] & ~ARESET;
  end

  // Payload is only rewritten on a master handshake; it is held across stalls
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      IDS_S   <= '0;
      ADDR_S  <= '0;
      LEN_S   <= '0;
      SIZE_S  <= '0;
      BURST_S <= '0;
    end else if (hs) begin
      IDS_S   <= {{(IDSW-IDW-2){1'b0}}, gnt_idx, sel_id};
      ADDR_S  <= sel_addr;
      LEN_S   <= sel_len;
      SIZE_S  <= sel_size;
      BURST_S <= sel_burst;
    end
  end

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// Bench for axi_addr_arbiter: directed vectors plus a cycle-level model of the arbiter.
// Build with or without AXI_ARB_RR_EN to match the design.
module tb_axi_addr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  id[3];
  logic [31:0] addr[3];
  logic [3:0]  len[3];
  logic [2:0]  size[3];
  logic [1:0]  burst[3];
  logic        valid[3];
  logic        rdy0, rdy1, rdy2;
  logic [7:0]  IDS_S;
  logic [31:0] ADDR_S;
  logic [3:0]  LEN_S;
  logic [2:0]  SIZE_S;
  logic [1:0]  BURST_S;
  logic        VALID_S;
  logic        READY_S;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 ACLK = ~ACLK;

  axi_addr_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ID_M0(id[0]), .ADDR_M0(addr[0]), .LEN_M0(len[0]), .SIZE_M0(size[0]),
    .BURST_M0(burst[0]), .VALID_M0(valid[0]), .READY_M0(rdy0),
    .ID_M1(id[1]), .ADDR_M1(addr[1]), .LEN_M1(len[1]), .SIZE_M1(size[1]),
    .BURST_M1(burst[1]), .VALID_M1(valid[1]), .READY_M1(rdy1),
    .ID_M2(id[2]), .ADDR_M2(addr[2]), .LEN_M2(len[2]), .SIZE_M2(size[2]),
    .BURST_M2(burst[2]), .VALID_M2(valid[2]), .READY_M2(rdy2),
    .IDS_S(IDS_S), .ADDR_S(ADDR_S), .LEN_S(LEN_S), .SIZE_S(SIZE_S),
    .BURST_S(BURST_S), .VALID_S(VALID_S), .READY_S(READY_S)
  );

  // Model: the beat the decoder should be seeing, plus arbitration priority
  bit          m_live = 1'b0;
  bit          m_valid;
  logic [7:0]  m_ids;
  logic [31:0] m_addr;
  logic [3:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
`ifdef AXI_ARB_RR_EN
  int          m_ptr;
`endif

  function automatic int pick();
    int m;
    if (m_valid && !READY_S) return -1;
    for (int k = 0; k < 3; k++) begin
`ifdef AXI_ARB_RR_EN
      m = (m_ptr + k) % 3;
`else
      m = k;
`endif
      if (valid[m]) return m;
    end
    return -1;
  endfunction

  always @(posedge ACLK) begin
    int p;
    if (ARESET) begin
      m_live  = 1'b1;
      m_valid = 1'b0;
      m_ids   = '0;
      m_addr  = '0;
      m_len   = '0;
      m_size  = '0;
      m_burst = '0;
`ifdef AXI_ARB_RR_EN
      m_ptr   = 0;
`endif
    end else if (m_live) begin
      p = pick();
      if (p >= 0) begin
        m_valid = 1'b1;
        m_ids   = {p[3:0], id[p]};
        m_addr  = addr[p];
        m_len   = len[p];
        m_size  = size[p];
        m_burst = burst[p];
`ifdef AXI_ARB_RR_EN
        m_ptr   = (p + 1) % 3;
`endif
      end else if (!m_valid || READY_S) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge ACLK) begin
    int p;
    if (m_live) begin
      p = pick();
      chk("model ready_m0", rdy0, !ARESET && p == 0);
      chk("model ready_m1", rdy1, !ARESET && p == 1);
      chk("model ready_m2", rdy2, !ARESET && p == 2);
      chk("model valid_s", VALID_S, m_valid);
      if (m_valid) begin
        chk("model ids_s", IDS_S, m_ids);
        chk("model addr_s", ADDR_S, m_addr);
        chk("model len_s", LEN_S, m_len);
        chk("model size_s", SIZE_S, m_size);
        chk("model burst_s", BURST_S, m_burst);
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [2:0] rvec();
    return {rdy2, rdy1, rdy0};
  endfunction

  initial begin
    logic [1:0] seq[4];
    ARESET  = 1'b1;
    READY_S = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id[i]    = 4'(i + 8);
      addr[i]  = 32'h1000_0000 + 32'(i);
      len[i]   = 4'(i + 1);
      size[i]  = 3'(i + 2);
      burst[i] = 2'b01;
      valid[i] = 1'b1;
    end

    // reset with all masters requesting
    step();
    step();
    chk("reset valid_s", VALID_S, 1'b0);
    chk("reset ready", rvec(), 3'b000);
    chk("reset ids_s", IDS_S, 8'h00);
    chk("reset addr_s", ADDR_S, 32'h0);
    chk("reset len_size_burst", {LEN_S, SIZE_S, BURST_S}, 9'h0);
    ARESET = 1'b0;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    step();

    // single beat from M1
    valid[1] = 1'b1;
    id[1]    = 4'h3;
    addr[1]  = 32'h0002_0010;
    READY_S  = 1'b1;
    @(negedge ACLK);
    chk("single ready", rvec(), 3'b010);
    step();
    valid[1] = 1'b0;
    READY_S  = 1'b0;
    valid[0] = 1'b1;
    id[0]    = 4'h5;
    addr[0]  = 32'h0000_00A0;

    // stall: beat held, M0 blocked
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk("stall valid_s", VALID_S, 1'b1);
      chk("stall ids_s", IDS_S, 8'h13);
      chk("stall addr_s", ADDR_S, 32'h0002_0010);
      chk("stall ready_m0", rdy0, 1'b0);
      step();
    end
    READY_S = 1'b1;
    @(negedge ACLK);
    chk("unstall ready_m0", rdy0, 1'b1);
    step();
    valid[0] = 1'b0;
    @(negedge ACLK);
    chk("unstall valid_s", VALID_S, 1'b1);
    chk("unstall ids_s", IDS_S, 8'h05);
    chk("unstall addr_s", ADDR_S, 32'h0000_00A0);
    step();
    @(negedge ACLK);
    chk("drain valid_s", VALID_S, 1'b0);

    // reset while FULL and stalled
    step();
    valid[2] = 1'b1;
    id[2]    = 4'hC;
    step();
    valid[2] = 1'b0;
    READY_S  = 1'b0;
    step();
    ARESET   = 1'b1;
    valid[0] = 1'b1;
    @(negedge ACLK);
    chk("midreset held valid_s", VALID_S, 1'b1);
    chk("midreset ready", rvec(), 3'b000);
    step();
    ARESET   = 1'b0;
    valid[0] = 1'b0;
    @(negedge ACLK);
    chk("midreset valid_s", VALID_S, 1'b0);
    step();

    for (int i = 0; i < 3; i++) begin
      id[i]   = 4'(i + 1);
      addr[i] = 32'hA000_0000 + 32'(i * 16);
    end
    READY_S = 1'b1;
`ifdef AXI_ARB_RR_EN
    // round-robin rotation under full contention
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0;
    for (int i = 0; i < 3; i++) valid[i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("rr ready", rvec(), 3'b001 << seq[k]);
      if (k > 0) chk("rr ids nibble", IDS_S[7:4], 4'(seq[k-1]));
      step();
    end
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    @(negedge ACLK);
    chk("rr ids nibble", IDS_S[7:4], 4'(seq[3]));
`else
    // fixed priority: M2 starves behind M0
    seq[0] = 2'd0; seq[1] = 2'd0; seq[2] = 2'd0; seq[3] = 2'd0;
    valid[0] = 1'b1;
    valid[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("fixed ready_m0", rdy0, 1'b1);
      chk("fixed ready_m2", rdy2, 1'b0);
      if (k > 0) chk("fixed ids nibble", IDS_S[7:4], 4'(seq[k-1]));
      step();
    end
    valid[0] = 1'b0;
    valid[2] = 1'b0;
`endif
    step();

    // mixed request / backpressure pattern, checked by the model
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 3; i++) begin
        valid[i] = ((c * 7 + i * 3) % 5) != 0 && ((c + i) % 3) != 0;
        id[i]    = 4'(c + i);
        addr[i]  = 32'h4000_0000 + 32'(c * 256 + i);
        len[i]   = 4'(c + 2 * i);
        size[i]  = 3'(c + i);
        burst[i] = 2'(c % 3);
      end
      READY_S = (c % 4) != 3 && (c % 11) != 5;
      step();
    end
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    READY_S = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
